seg_scan_n: RTL and testbench

Parametrised multiplexed seven-segment scanner for the board top level: drives DIGITS common-anode digits from a 4·DIGITS-bit hex word, at a programmable refresh rate from the 100 MHz board clock. Over a fixed 8-digit hex scanner it adds:
- double-buffered, frame-aligned display updates
- per-digit decimal points
- per-digit blink
- optional leading-zero blanking
- a frame-done strobe

It replaces the inline scan logic in the board wrapper and takes its display word from the debug/PC mux.

---
 rtl/seg_scan_n_if.sv | 41 ++++
 rtl/seg_scan_n.sv | 212 +++++++++++++++++++++
 tb/tb_seg_scan_n.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_n_if.sv
// ---------------------------------------------------------------------------
// seg_scan_n_if
//   Bundles the display-side signals of the seven-segment scanner.
//
//   Source side (master drives, slave receives):
//     data      [4*DIGITS]  hex nibbles, nibble i -> digit i (digit 0 rightmost)
//     dp        [DIGITS]    decimal-point enables
//     blink     [DIGITS]    blink enables
//     load                  capture data/dp/blink into the pending buffer
//     blank_lz              leading-zero blanking enable (live)
//   Display side (slave drives, master receives):
//     seg       [7]         segments a..g, active-low, seg[0]=a
//     dp_n                  decimal point, active-low
//     an        [DIGITS]    digit enables, active-low
//     busy                  pending buffer not yet shown
//     frame_done            one-cycle pulse per frame wrap
// ---------------------------------------------------------------------------
interface seg_scan_n_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blink;
  logic                load;
  logic                blank_lz;
  logic [6:0]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;
  logic                busy;
  logic                frame_done;

  modport master (
    output data, dp, blink, load, blank_lz,
    input  seg, dp_n, an, busy, frame_done
  );

  modport slave (
    input  data, dp, blink, load, blank_lz,
    output seg, dp_n, an, busy, frame_done
  );
endinterface

// File: rtl/seg_scan_n.sv
// ---------------------------------------------------------------------------
// seg_scan_n
//   Multiplexed common-anode seven-segment scanner. Scans DIGITS digits, one
//   slot of TICK_DIV clocks each, from a double-buffered display word. New
//   words land in a pending buffer on load and move to the display buffer
//   only at a frame wrap, so a frame never shows a mix of old and new data.
//   Adds per-digit decimal points, per-digit blink (BLINK_FRAMES frames per
//   half-period), optional leading-zero blanking and a frame-done strobe.
//
//   Ports:
//     CLK100MHZ  board clock, all state on its rising edge
//     reset      asynchronous active-high reset; blanks the display at once
//     bus        seg_scan_n_if slave modport (data/dp/blink/load/blank_lz in,
//                seg/dp_n/an/busy/frame_done out)
// ---------------------------------------------------------------------------
module seg_scan_n #(
  parameter int DIGITS       = 8,
  parameter int TICK_DIV     = 262144,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  seg_scan_n_if.slave   bus
);

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DATA_W = 4 * DIGITS;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  // Hex digit to active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Timing state
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic              frame_done_q, frame_done_d;

  // Pending and display buffers
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0] pend_blink_q, pend_blink_d;
  logic              pend_v_q, pend_v_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0] disp_blink_q, disp_blink_d;

  // Registered drive
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;

  logic       tick;
  logic       frame_edge;
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_blink;
  logic       upper_zero;
  logic       dark;

  // ---- slot / frame timing ----
  always_comb begin
    tick       = (pre_q == PRE_LAST);
    frame_edge = tick && (idx_q == IDX_LAST);

    pre_d = tick ? '0 : pre_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_edge) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    frame_done_d = frame_edge;
  end

  // ---- double buffer ----
  // The frame-edge transfer reads the registered pending contents, so a load
  // on that same edge is not shown this frame; it stays pending instead.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    pend_v_d     = pend_v_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blink_d = disp_blink_q;

    if (frame_edge && pend_v_q) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blink_d = pend_blink_q;
      pend_v_d     = 1'b0;
    end

    if (bus.load) begin
      pend_data_d  = bus.data;
      pend_dp_d    = bus.dp;
      pend_blink_d = bus.blink;
      pend_v_d     = 1'b1;
    end
  end

  // ---- digit select and decode ----
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        cur_nib   = disp_data_q[4*j +: 4];
        cur_dp    = disp_dp_q[j];
        cur_blink = disp_blink_q[j];
      end
      // Any nonzero nibble at or above the current digit keeps it lit.
      if ((j >= int'(idx_q)) && (disp_data_q[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end

    dark = (phase_q && cur_blink) ||
           (bus.blank_lz && (idx_q != '0) && upper_zero);

    for (int j = 0; j < DIGITS; j++) begin
      an_d[j] = !(!dark && (idx_q == IDX_W'(j)));
    end
    seg_d  = dark ? 7'b1111111 : hex_seg(cur_nib);
    dp_n_d = dark || !cur_dp;
  end

  // ---- state registers ----
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      frame_done_q <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_v_q     <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      frame_done_q <= frame_done_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blink_q <= pend_blink_d;
      pend_v_q     <= pend_v_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blink_q <= disp_blink_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.busy       = pend_v_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_n.sv
// Directed bench for seg_scan_n with DIGITS=4, TICK_DIV=4, BLINK_FRAMES=2.
// n counts rising edges since reset release; outputs are sampled 1 time unit
// after each edge. A frame edge occurs at every n that is a multiple of 16,
// and the frame loaded there is visible after edges n+1 .. n+16, digit d
// after edges n+4d+1 .. n+4d+4.
module tb_seg_scan_n;
  localparam int DIGITS       = 4;
  localparam int TICK_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0001110;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  int   n;
  int   passed = 0;
  int   total  = 0;

  seg_scan_n_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_n #(
    .DIGITS(DIGITS),
    .TICK_DIV(TICK_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .CLK100MHZ(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic to_frame_edge();
    step();
    while (n % 16 != 0) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.data  = d;
    bus.dp    = p;
    bus.blink = b;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.data     = '0;
    bus.dp       = '0;
    bus.blink    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    n            = 0;
    repeat (3) step();
    total++; if (bus.an !== 4'b1111) $display("FAIL reset_an got=%b want=1111", bus.an); else passed++;
    total++; if (bus.seg !== SOFF) $display("FAIL reset_seg got=%b want=%b", bus.seg, SOFF); else passed++;
    total++; if (bus.dp_n !== 1'b1) $display("FAIL reset_dp_n got=%b want=1", bus.dp_n); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else passed++;
    total++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b want=0", bus.frame_done); else passed++;
    rst = 1'b0;
    n   = 0;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    int pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_an = 4'hF ^ (4'h1 << (((k - 1) / 4) % 4));
      total++; if (bus.an !== exp_an) $display("FAIL scan_an edge=%0d got=%b want=%b", k, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== S0) $display("FAIL scan_seg edge=%0d got=%b want=%b", k, bus.seg, S0); else passed++;
      total++; if (bus.frame_done !== (k == 16)) $display("FAIL scan_frame_done edge=%0d got=%b want=%b", k, bus.frame_done, (k == 16)); else passed++;
      if (bus.frame_done === 1'b1) pulses++;
    end
    total++; if (pulses != 1) $display("FAIL scan_pulse_count got=%0d want=1", pulses); else passed++;
  endtask

  task automatic test_load();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    int d;
    exp_seg[0] = SF; exp_seg[1] = SA; exp_seg[2] = S2; exp_seg[3] = S1;
    do_load(16'h12AF, 4'b0001, 4'b0000);
    total++; if (bus.busy !== 1'b1) $display("FAIL load_busy_rise got=%b want=1", bus.busy); else passed++;
    while (n < 31) step();
    total++; if (bus.busy !== 1'b1) $display("FAIL load_busy_hold got=%b want=1", bus.busy); else passed++;
    step();
    total++; if (bus.busy !== 1'b0) $display("FAIL load_busy_fall got=%b want=0", bus.busy); else passed++;
    total++; if (bus.frame_done !== 1'b1) $display("FAIL load_frame_done got=%b want=1", bus.frame_done); else passed++;
    for (int e = 1; e <= 16; e++) begin
      step();
      d = (e - 1) / 4;
      exp_an = 4'hF ^ (4'h1 << d);
      total++; if (bus.an !== exp_an) $display("FAIL load_an edge=%0d got=%b want=%b", e, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== exp_seg[d]) $display("FAIL load_seg digit=%0d got=%b want=%b", d, bus.seg, exp_seg[d]); else passed++;
      total++; if (bus.dp_n !== (d != 0)) $display("FAIL load_dp_n digit=%0d got=%b want=%b", d, bus.dp_n, (d != 0)); else passed++;
    end
  endtask

  task automatic test_lz();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic       lit;
    int d;
    bus.blank_lz = 1'b1;
    // 0x0030: digits 3,2 blanked, digit 1 shows 3, digit 0 shows 0
    exp_seg[0] = S0; exp_seg[1] = S3; exp_seg[2] = SOFF; exp_seg[3] = SOFF;
    do_load(16'h0030, 4'b0000, 4'b0000);
    to_frame_edge();
    for (int e = 1; e <= 16; e++) begin
      step();
      d = (e - 1) / 4;
      lit = (d < 2);
      exp_an = lit ? (4'hF ^ (4'h1 << d)) : 4'hF;
      total++; if (bus.an !== exp_an) $display("FAIL lz30_an digit=%0d got=%b want=%b", d, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== exp_seg[d]) $display("FAIL lz30_seg digit=%0d got=%b want=%b", d, bus.seg, exp_seg[d]); else passed++;
    end
    // 0x0000: only digit 0 lit
    do_load(16'h0000, 4'b1111, 4'b0000);
    to_frame_edge();
    for (int e = 1; e <= 16; e++) begin
      step();
      d = (e - 1) / 4;
      exp_an = (d == 0) ? 4'b1110 : 4'b1111;
      total++; if (bus.an !== exp_an) $display("FAIL lz00_an digit=%0d got=%b want=%b", d, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== ((d == 0) ? S0 : SOFF)) $display("FAIL lz00_seg digit=%0d got=%b", d, bus.seg); else passed++;
      total++; if (bus.dp_n !== (d != 0)) $display("FAIL lz00_dp_n digit=%0d got=%b want=%b", d, bus.dp_n, (d != 0)); else passed++;
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    logic       ph;
    int d;
    exp_seg[0] = S1; exp_seg[1] = S2; exp_seg[2] = S3; exp_seg[3] = S4;
    do_load(16'h4321, 4'b0000, 4'b0100);
    to_frame_edge();
    for (int f = 0; f < 4; f++) begin
      // phase toggles every second frame edge counted from release
      ph = (((n / 16) / 2) % 2) == 1;
      for (int e = 1; e <= 16; e++) begin
        step();
        d = (e - 1) / 4;
        exp_an = (ph && d == 2) ? 4'hF : (4'hF ^ (4'h1 << d));
        total++; if (bus.an !== exp_an) $display("FAIL blink_an frame=%0d digit=%0d got=%b want=%b", f, d, bus.an, exp_an); else passed++;
        total++; if (bus.seg !== ((ph && d == 2) ? SOFF : exp_seg[d])) $display("FAIL blink_seg frame=%0d digit=%0d got=%b", f, d, bus.seg); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_an;
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    while (n % 16 != 15) step();
    do_load(16'h3333, 4'b0000, 4'b0000);
    total++; if (n % 16 != 0) $display("FAIL b2b_align got=%0d want=0", n % 16); else passed++;
    total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy_edge got=%b want=1", bus.busy); else passed++;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_an = 4'hF ^ (4'h1 << ((e - 1) / 4));
      total++; if (bus.an !== exp_an) $display("FAIL b2b_first_an edge=%0d got=%b want=%b", e, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== S2) $display("FAIL b2b_first_seg edge=%0d got=%b want=%b", e, bus.seg, S2); else passed++;
    end
    total++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_fall got=%b want=0", bus.busy); else passed++;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_an = 4'hF ^ (4'h1 << ((e - 1) / 4));
      total++; if (bus.an !== exp_an) $display("FAIL b2b_second_an edge=%0d got=%b want=%b", e, bus.an, exp_an); else passed++;
      total++; if (bus.seg !== S3) $display("FAIL b2b_second_seg edge=%0d got=%b want=%b", e, bus.seg, S3); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    do_load(16'h5555, 4'b1111, 4'b0000);
    total++; if (bus.busy !== 1'b1) $display("FAIL rmid_busy_pre got=%b want=1", bus.busy); else passed++;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.an !== 4'b1111) $display("FAIL rmid_an got=%b want=1111", bus.an); else passed++;
    total++; if (bus.seg !== SOFF) $display("FAIL rmid_seg got=%b want=%b", bus.seg, SOFF); else passed++;
    total++; if (bus.dp_n !== 1'b1) $display("FAIL rmid_dp_n got=%b want=1", bus.dp_n); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rmid_busy got=%b want=0", bus.busy); else passed++;
    step();
    rst = 1'b0;
    n   = 0;
    step();
    total++; if (bus.an !== 4'b1110) $display("FAIL rmid_rel_an got=%b want=1110", bus.an); else passed++;
    total++; if (bus.seg !== S0) $display("FAIL rmid_rel_seg got=%b want=%b", bus.seg, S0); else passed++;
    total++; if (bus.dp_n !== 1'b1) $display("FAIL rmid_rel_dp_n got=%b want=1", bus.dp_n); else passed++;
    while (n < 17) step();
    total++; if (bus.seg !== S0) $display("FAIL rmid_lost_seg got=%b want=%b", bus.seg, S0); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rmid_lost_busy got=%b want=0", bus.busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
